// File: rtl/tqvp_hx2003_pulse_tx_scheduler_pkg.sv
// rtl/tqvp_hx2003_pulse_tx_scheduler_pkg.sv - shared types and constants for the pulse TX scheduler
//
// Purpose : scheduler state encoding, job record layout and the arm timeout.
// Contents: END_W / LOOPBACK_W / LOOP_CNT_W field widths (7/7/8),
//           ARM_W / ARM_TIMEOUT arm watchdog width and limit (15 cycles),
//           state_t scheduler states, job_fields_t queued job record.
package tqvp_hx2003_pulse_tx_scheduler_pkg;

  localparam int END_W       = 7;
  localparam int LOOPBACK_W  = 7;
  localparam int LOOP_CNT_W  = 8;
  localparam int ARM_W       = 4;
  localparam int ARM_TIMEOUT = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_RUN,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic [END_W-1:0]      end_index;
    logic [LOOPBACK_W-1:0] loopback_index;
    logic [LOOP_CNT_W-1:0] loop_count;
  } job_fields_t;

  localparam int JOB_FIELDS_W = $bits(job_fields_t);

endpackage

// File: rtl/tqvp_hx2003_pulse_tx_scheduler_job_fifo.sv
// rtl/tqvp_hx2003_pulse_tx_scheduler_job_fifo.sv - register-based job FIFO
//
// Purpose : DEPTH-entry flop FIFO holding queued jobs, first-word-fall-through head.
// Ports   : clk, rst_n (sync, active-low), flush (sync empty),
//           push / push_data (write), pop (advance head),
//           head_data (current head entry), count (entries held, 0..DEPTH).
module tqvp_hx2003_pulse_job_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Local guards keep the count consistent even if a caller misbehaves.
  assign do_push   = push && (count != CW'(DEPTH));
  assign do_pop    = pop && (count != '0);
  assign head_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is plain flops with no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tqvp_hx2003_pulse_tx_scheduler.sv
// rtl/tqvp_hx2003_pulse_tx_scheduler.sv - queued job scheduler driving the pulse transmitter
//
// Purpose : queues transmit jobs and sequences them onto the transmitter with
//           arm watchdog, inter-job gap, abort flush and sticky interrupt.
// Ports   : clk, rst_n (sync, active-low)
//           job_valid/job_ready + job_end_index/job_loopback_index/job_loop_count/job_gap
//           enable (allow new jobs), abort (flush), tx_active (transmitter status)
//           tx_start + tx_end_index/tx_loopback_index/tx_loop_count (to transmitter)
//           busy, pending, job_done, timeout_err, irq/irq_clear
module tqvp_hx2003_pulse_tx_scheduler
  import tqvp_hx2003_pulse_tx_scheduler_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [END_W-1:0]       job_end_index,
  input  logic [LOOPBACK_W-1:0]  job_loopback_index,
  input  logic [LOOP_CNT_W-1:0]  job_loop_count,
  input  logic [GAP_W-1:0]       job_gap,
  input  logic                   enable,
  input  logic                   abort,
  input  logic                   tx_active,
  output logic                   tx_start,
  output logic [END_W-1:0]       tx_end_index,
  output logic [LOOPBACK_W-1:0]  tx_loopback_index,
  output logic [LOOP_CNT_W-1:0]  tx_loop_count,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   job_done,
  output logic                   timeout_err,
  output logic                   irq,
  input  logic                   irq_clear
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int FW = JOB_FIELDS_W + GAP_W;

  state_t           state;
  logic [ARM_W-1:0] arm_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             push;
  logic             pop;
  logic             irq_set;
  job_fields_t      in_fields;
  job_fields_t      head_fields;
  logic [GAP_W-1:0] head_gap;
  logic [FW-1:0]    head_data;

  assign job_ready = (pending != PW'(DEPTH)) && !abort;
  assign push      = job_valid && job_ready;
  assign pop       = (state == ST_LOAD) && !abort;

  assign in_fields.end_index      = job_end_index;
  assign in_fields.loopback_index = job_loopback_index;
  assign in_fields.loop_count     = job_loop_count;
  assign {head_gap, head_fields}  = head_data;

  tqvp_hx2003_pulse_job_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_job_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (push),
    .push_data ({job_gap, in_fields}),
    .pop       (pop),
    .head_data (head_data),
    .count     (pending)
  );

  // Completion and watchdog pulses belong to the cycle where the condition
  // is seen; an abort (or reset) in that same cycle cancels the job silently.
  assign job_done    = rst_n && !abort && (state == ST_RUN) && !tx_active;
  assign timeout_err = rst_n && !abort && (state == ST_ARM) && !tx_active &&
                       (arm_cnt == ARM_W'(ARM_TIMEOUT - 1));
  // The LOAD pop has already happened, so pending == 0 here means drained.
  assign irq_set     = (job_done && (pending == '0)) || timeout_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      tx_start          <= 1'b0;
      busy              <= 1'b0;
      tx_end_index      <= '0;
      tx_loopback_index <= '0;
      tx_loop_count     <= '0;
      arm_cnt           <= '0;
      gap_cnt           <= '0;
      irq               <= 1'b0;
    end else begin
      if (irq_set)        irq <= 1'b1;
      else if (irq_clear) irq <= 1'b0;

      if (abort) begin
        state    <= ST_IDLE;
        tx_start <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            // Counting the incoming push lets a job into an empty queue
            // reach LOAD on the next cycle; its fields are still taken
            // from the FIFO, never straight from the inputs.
            if (enable && ((pending != '0) || push)) begin
              state <= ST_LOAD;
              busy  <= 1'b1;
            end
          end
          ST_LOAD: begin
            tx_end_index      <= head_fields.end_index;
            tx_loopback_index <= head_fields.loopback_index;
            tx_loop_count     <= head_fields.loop_count;
            gap_cnt           <= head_gap;
            arm_cnt           <= '0;
            tx_start          <= 1'b1;
            state             <= ST_ARM;
          end
          ST_ARM: begin
            if (tx_active) begin
              state <= ST_RUN;
            end else if (arm_cnt == ARM_W'(ARM_TIMEOUT - 1)) begin
              state    <= ST_GAP;
              tx_start <= 1'b0;
            end else begin
              arm_cnt <= arm_cnt + 1'b1;
            end
          end
          ST_RUN: begin
            if (!tx_active) begin
              state    <= ST_GAP;
              tx_start <= 1'b0;
            end
          end
          ST_GAP: begin
            // A gap of g gives max(g,1) cycles, so tx_start always drops
            // for at least one cycle between jobs.
            if (gap_cnt <= GAP_W'(1)) begin
              if (enable && (pending != '0)) begin
                state <= ST_LOAD;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
          default: begin
            state    <= ST_IDLE;
            tx_start <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tqvp_hx2003_pulse_tx_scheduler.sv
// tb/tb_tqvp_hx2003_pulse_tx_scheduler.sv - self-checking bench for the pulse TX scheduler
module tb_tqvp_hx2003_pulse_tx_scheduler;

  localparam int DEPTH = 4;
  localparam int GAP_W = 16;
  localparam int PW    = 3;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_ARM  = 2;
  localparam int P_RUN  = 3;
  localparam int P_GAP  = 4;

  typedef struct {
    int e;
    int lb;
    int c;
    int g;
  } job_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             job_valid = 1'b0;
  logic             job_ready;
  logic [6:0]       job_end_index = '0;
  logic [6:0]       job_loopback_index = '0;
  logic [7:0]       job_loop_count = '0;
  logic [GAP_W-1:0] job_gap = '0;
  logic             enable = 1'b0;
  logic             abort = 1'b0;
  logic             tx_active = 1'b0;
  logic             tx_start;
  logic [6:0]       tx_end_index;
  logic [6:0]       tx_loopback_index;
  logic [7:0]       tx_loop_count;
  logic             busy;
  logic [PW-1:0]    pending;
  logic             job_done;
  logic             timeout_err;
  logic             irq;
  logic             irq_clear = 1'b0;

  tqvp_hx2003_pulse_tx_scheduler #(.DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .job_valid          (job_valid),
    .job_ready          (job_ready),
    .job_end_index      (job_end_index),
    .job_loopback_index (job_loopback_index),
    .job_loop_count     (job_loop_count),
    .job_gap            (job_gap),
    .enable             (enable),
    .abort              (abort),
    .tx_active          (tx_active),
    .tx_start           (tx_start),
    .tx_end_index       (tx_end_index),
    .tx_loopback_index  (tx_loopback_index),
    .tx_loop_count      (tx_loop_count),
    .busy               (busy),
    .pending            (pending),
    .job_done           (job_done),
    .timeout_err        (timeout_err),
    .irq                (irq),
    .irq_clear          (irq_clear)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: job queue plus the job currently owned by the scheduler
  job_t mq[$];
  job_t m_cur;
  int   m_phase = P_IDLE;
  int   arm_n = 0;
  int   gap_left = 0;
  bit   m_irq = 1'b0;

  // transmitter environment
  int env_mode = 0;
  int lat = 0;
  int len = 0;
  int tx_age = 0;

  // observations of DUT behaviour
  int done_cnt, to_cnt, rise_cnt, acc_cnt, gap_obs, to_at, hi_run, low_run;
  bit prev_txs;
  int seps[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic clear_obs();
    done_cnt = 0; to_cnt = 0; rise_cnt = 0; acc_cnt = 0; gap_obs = 0;
    to_at = 0; hi_run = 0; low_run = 0; prev_txs = 1'b0;
    seps.delete();
  endtask

  function automatic int gap_cycles(input int g);
    return (g == 0) ? 1 : g;
  endfunction

  task automatic model_step();
    int   sz;
    bit   push;
    bit   mdone;
    bit   mto;
    job_t nj;
    sz    = mq.size();
    push  = job_valid && (sz < DEPTH) && !abort;
    mdone = !abort && (m_phase == P_RUN) && !tx_active;
    mto   = !abort && (m_phase == P_ARM) && !tx_active && (arm_n == 15);
    nj    = '{int'(job_end_index), int'(job_loopback_index), int'(job_loop_count), int'(job_gap)};
    if (!rst_n) begin
      mq.delete();
      m_phase = P_IDLE;
      m_irq   = 1'b0;
      m_cur   = '{0, 0, 0, 0};
      return;
    end
    if ((mdone && sz == 0) || mto) m_irq = 1'b1;
    else if (irq_clear)           m_irq = 1'b0;
    if (abort) begin
      mq.delete();
      m_phase = P_IDLE;
      return;
    end
    case (m_phase)
      P_IDLE: if (enable && (sz > 0 || push)) m_phase = P_LOAD;
      P_LOAD: begin
        m_cur   = mq.pop_front();
        arm_n   = 1;
        m_phase = P_ARM;
      end
      P_ARM: begin
        if (tx_active) m_phase = P_RUN;
        else if (arm_n == 15) begin
          m_phase  = P_GAP;
          gap_left = gap_cycles(m_cur.g);
        end else arm_n++;
      end
      P_RUN: begin
        if (!tx_active) begin
          m_phase  = P_GAP;
          gap_left = gap_cycles(m_cur.g);
        end
      end
      default: begin
        gap_left--;
        if (gap_left == 0) m_phase = (enable && sz > 0) ? P_LOAD : P_IDLE;
      end
    endcase
    if (push) mq.push_back(nj);
  endtask

  task automatic tick();
    bit m_txs, m_busy, m_ready, m_done, m_to;
    if (m_phase == P_ARM || m_phase == P_RUN) tx_age++;
    else tx_age = 0;
    case (env_mode)
      1:       tx_active = (tx_age > lat) && (tx_age <= lat + len);
      2:       tx_active = 1'($urandom_range(0, 1));
      default: tx_active = 1'b0;
    endcase
    #2;
    m_txs   = (m_phase == P_ARM) || (m_phase == P_RUN);
    m_busy  = (m_phase != P_IDLE);
    m_ready = (mq.size() < DEPTH) && !abort;
    m_done  = rst_n && !abort && (m_phase == P_RUN) && !tx_active;
    m_to    = rst_n && !abort && (m_phase == P_ARM) && !tx_active && (arm_n == 15);
    chk("tx_start", 32'(tx_start), 32'(m_txs));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("pending", 32'(pending), 32'(mq.size()));
    chk("job_ready", 32'(job_ready), 32'(m_ready));
    chk("job_done", 32'(job_done), 32'(m_done));
    chk("timeout_err", 32'(timeout_err), 32'(m_to));
    chk("irq", 32'(irq), 32'(m_irq));
    if (m_txs) begin
      chk("tx_end_index", 32'(tx_end_index), 32'(m_cur.e));
      chk("tx_loopback_index", 32'(tx_loopback_index), 32'(m_cur.lb));
      chk("tx_loop_count", 32'(tx_loop_count), 32'(m_cur.c));
    end
    if (tx_start) hi_run++;
    else hi_run = 0;
    if (job_done) done_cnt++;
    if (timeout_err) begin
      to_cnt++;
      to_at = hi_run;
    end
    if (tx_start && !prev_txs) begin
      rise_cnt++;
      if (rise_cnt > 1) seps.push_back(low_run);
    end
    if (!tx_start) low_run++;
    else low_run = 0;
    if (busy && !tx_start && rise_cnt > 0) gap_obs++;
    if (job_valid && job_ready) acc_cnt++;
    prev_txs = tx_start;
    model_step();
    @(posedge clk);
    #1;
    job_valid = 1'b0;
    abort     = 1'b0;
    irq_clear = 1'b0;
  endtask

  task automatic set_job(input int e, input int lb, input int c, input int g);
    job_end_index      = 7'(e);
    job_loopback_index = 7'(lb);
    job_loop_count     = 8'(c);
    job_gap            = GAP_W'(g);
  endtask

  task automatic push_job(input int e, input int lb, input int c, input int g);
    set_job(e, lb, c, g);
    job_valid = 1'b1;
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pending"}, 32'(pending), 32'd0);
    chk({tag, "_irq"}, 32'(irq), 32'd0);
    chk({tag, "_job_ready"}, 32'(job_ready), 32'd1);
    chk({tag, "_job_done"}, 32'(job_done), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_tx_fields"}, 32'({tx_end_index, tx_loopback_index, tx_loop_count}), 32'd0);
  endtask

  task automatic do_reset();
    enable   = 1'b0;
    env_mode = 0;
    rst_n    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check_reset_values("rst");
    clear_obs();
  endtask

  initial begin
    clear_obs();
    @(posedge clk);
    #1;
    do_reset();

    // single job: end 5, loop 2, gap 10; transmitter active 3 cycles after start
    enable = 1'b1; env_mode = 1; lat = 3; len = 20;
    push_job(5, 1, 2, 10);
    chk("s1_load_no_start", 32'(tx_start), 32'd0);
    tick();
    chk("s1_start_n_plus_2", 32'(tx_start), 32'd1);
    for (int i = 0; i < 60; i++) tick();
    chk("s1_done_once", 32'(done_cnt), 32'd1);
    chk("s1_gap_low_cycles", 32'(gap_obs), 32'd10);
    chk("s1_irq", 32'(irq), 32'd1);

    // overfill a DEPTH-4 queue with scheduling disabled
    do_reset();
    for (int i = 0; i < 5; i++) push_job(i + 1, i, i * 3, 2);
    chk("s2_accepted", 32'(acc_cnt), 32'd4);
    chk("s2_pending", 32'(pending), 32'd4);
    chk("s2_ready_low", 32'(job_ready), 32'd0);

    // three back-to-back jobs with zero gap
    do_reset();
    for (int i = 0; i < 3; i++) push_job(10 + i, 20 + i, 30 + i, 0);
    enable = 1'b1; env_mode = 1; lat = 1; len = 2;
    for (int i = 0; i < 200 && done_cnt < 3; i++) tick();
    for (int i = 0; i < 4; i++) tick();
    chk("s3_rises", 32'(rise_cnt), 32'd3);
    chk("s3_done", 32'(done_cnt), 32'd3);
    chk("s3_irq", 32'(irq), 32'd1);
    chk("s3_sep_count", 32'(seps.size()), 32'd2);
    foreach (seps[k]) chk("s3_separation", 32'(seps[k]), 32'd2);

    // arm timeout, then the next job still runs
    do_reset();
    enable = 1'b1; env_mode = 0;
    push_job(7, 3, 9, 1);
    push_job(8, 4, 10, 1);
    for (int i = 0; i < 100 && to_cnt < 1; i++) tick();
    chk("s4_timeout", 32'(to_cnt), 32'd1);
    chk("s4_timeout_at_arm15", 32'(to_at), 32'd15);
    chk("s4_irq", 32'(irq), 32'd1);
    env_mode = 1; lat = 1; len = 3;
    for (int i = 0; i < 100 && done_cnt < 1; i++) tick();
    chk("s4_next_done", 32'(done_cnt), 32'd1);

    // abort while running with two jobs queued
    do_reset();
    for (int i = 0; i < 3; i++) push_job(40 + i, 2, 5, 3);
    enable = 1'b1; env_mode = 1; lat = 1; len = 50;
    for (int i = 0; i < 50 && m_phase != P_RUN; i++) tick();
    tick();
    chk("s5_pending_run", 32'(pending), 32'd2);
    abort = 1'b1;
    tick();
    chk("s5_tx_start", 32'(tx_start), 32'd0);
    chk("s5_pending", 32'(pending), 32'd0);
    chk("s5_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("s5_no_done", 32'(done_cnt), 32'd0);

    // push during LOAD keeps pending, then reset mid-run
    do_reset();
    push_job(1, 1, 1, 0);
    push_job(2, 2, 2, 0);
    chk("s6_pending_pre", 32'(pending), 32'd2);
    enable = 1'b1; env_mode = 1; lat = 2; len = 30;
    tick();
    set_job(3, 3, 3, 0);
    job_valid = 1'b1;
    tick();
    chk("s6_pending_same", 32'(pending), 32'd2);
    for (int i = 0; i < 50 && m_phase != P_RUN; i++) tick();
    tick();
    chk("s6_running", 32'(tx_start), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_values("s6_midrun");

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i % 64 == 0) begin
        env_mode = $urandom_range(0, 2);
        lat      = $urandom_range(0, 5);
        len      = $urandom_range(1, 8);
      end
      set_job($urandom_range(0, 127), $urandom_range(0, 127),
              $urandom_range(0, 255), $urandom_range(0, 3));
      job_valid = ($urandom_range(0, 99) < 35);
      enable    = ($urandom_range(0, 99) < 85);
      abort     = ($urandom_range(0, 99) < 2);
      irq_clear = ($urandom_range(0, 99) < 10);
      rst_n     = ($urandom_range(0, 999) >= 5);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
